// File: rtl/inst_fetch.sv
// Instruction fetch stage: in-order word requests to instruction memory, a prefetch FIFO and the decode output register.
// Build option IF_ENDIAN_SWAP_EN byte-swaps each returned word before it is buffered (big-endian core, little-endian memory).
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   CAP      = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          id_valid_q, id_valid_d;
  logic [31:0]   id_pc_q, id_pc_d;
  logic [31:0]   id_inst_q, id_inst_d;
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];

  logic          req;
  logic          fire;
  logic          resp_ok;
  logic          push;
  logic          pop;
  logic [31:0]   rdata_fmt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

`ifdef IF_ENDIAN_SWAP_EN
  assign rdata_fmt = {imem_rdata_i[7:0], imem_rdata_i[15:8], imem_rdata_i[23:16], imem_rdata_i[31:24]};
`else
  assign rdata_fmt = imem_rdata_i;
`endif

  // Memory handshake: a request transfers when imem_req_o && imem_gnt_i; responses come back
  // in request order on imem_rvalid_i, each consuming one outstanding request. The cap on
  // outstanding + buffered words guarantees every accepted response has a FIFO slot.
  assign req     = rst && (({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < CAP) && !branch_flag_i;
  assign fire    = req && imem_gnt_i;
  assign resp_ok = imem_rvalid_i && (out_cnt_q != '0);
  assign push    = resp_ok && (drop_cnt_q == '0) && !branch_flag_i;
  assign pop     = !branch_flag_i && !stall_i && (fifo_cnt_q != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;

    if (fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      out_cnt_d  = out_cnt_d + CW'(1);
    end
    if (resp_ok) begin
      out_cnt_d = out_cnt_d - CW'(1);
      if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
    end
    if (push) begin
      resp_pc_d  = resp_pc_q + 32'd4;
      wr_ptr_d   = ptr_inc(wr_ptr_q);
      fifo_cnt_d = fifo_cnt_d + CW'(1);
    end
    if (pop) begin
      rd_ptr_d   = ptr_inc(rd_ptr_q);
      fifo_cnt_d = fifo_cnt_d - CW'(1);
    end

    if (branch_flag_i) begin
      // Every request still outstanding after this cycle belongs to the abandoned path.
      fetch_pc_d = branch_target_i;
      resp_pc_d  = branch_target_i;
      drop_cnt_d = resp_ok ? out_cnt_q - CW'(1) : out_cnt_q;
      fifo_cnt_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      id_valid_d = 1'b0;
      id_pc_d    = '0;
      id_inst_d  = '0;
    end else if (!stall_i) begin
      if (fifo_cnt_q != '0) begin
        id_valid_d = 1'b1;
        id_pc_d    = fifo_pc_q[rd_ptr_q];
        id_inst_d  = fifo_inst_q[rd_ptr_q];
      end else begin
        id_valid_d = 1'b0;
        id_pc_d    = '0;
        id_inst_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

  // Storage needs no reset: the count and pointers decide what is readable.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
      fifo_inst_q[wr_ptr_q] <= rdata_fmt;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc_q;
  assign id_valid_o  = id_valid_q;
  assign id_pc_o     = id_pc_q;
  assign id_inst_o   = id_inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: acts as instruction memory and checks every cycle against a queue-based fetch model.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;
`ifdef IF_ENDIAN_SWAP_EN
  localparam logic [31:0] FIRST_INST  = 32'h0011_0134;
  localparam logic [31:0] SECOND_INST = 32'h0C11_0534;
  localparam logic [31:0] SWAP_INST   = 32'h3434_0011;
`else
  localparam logic [31:0] FIRST_INST  = 32'h3401_1100;
  localparam logic [31:0] SECOND_INST = 32'h3405_110C;
  localparam logic [31:0] SWAP_INST   = 32'h1100_3434;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  inst_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o)
  );

  // ---------------- clock / watchdog ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded, expected finish");
    $fatal(1);
  end

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;
    bit          doomed;
    int          due;
  } fl_t;

  fl_t         flight_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] m_fetch_pc;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  int          cyc = 0;

  bit          k_stall = 0;
  bit          k_br = 0;
  logic [31:0] k_tgt = '0;
  int          k_gnt_pct = 100;
  int          k_rv_pct = 100;
  int          k_lat = 1;
  bit          k_spur = 0;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h200) return 32'h1100_3434;
    return a * 32'h0001_0003 + 32'h3401_1100;
  endfunction

  function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef IF_ENDIAN_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch_pc = RST_PC;
    m_valid    = 1'b0;
    m_pc       = '0;
    m_inst     = '0;
    exp_q.delete();
    flight_q.delete();
  endtask

  task automatic drive_idle();
    stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
  endtask

  // One clock: drive memory/decode inputs, check the request side, advance the model, check outputs.
  task automatic step();
    fl_t         e;
    logic [63:0] ent;
    bit          exp_req, fire, rv, take;
    stall_i         = k_stall;
    branch_flag_i   = k_br;
    branch_target_i = k_tgt;
    imem_gnt_i      = ($urandom_range(0, 99) < k_gnt_pct);
    if (flight_q.size() > 0)
      rv = (cyc >= flight_q[0].due) && ($urandom_range(0, 99) < k_rv_pct);
    else
      rv = k_spur && ($urandom_range(0, 99) < 5);
    imem_rvalid_i = rv;
    imem_rdata_i  = (rv && flight_q.size() > 0) ? mem_word(flight_q[0].addr) : $urandom();
    #1;
    exp_req = (flight_q.size() + exp_q.size() < DEPTH) && !k_br;
    chk("imem_req_o", 32'(imem_req_o), 32'(exp_req));
    chk("imem_addr_o", imem_addr_o, m_fetch_pc);
    fire = exp_req && imem_gnt_i;
    take = 0;
    if (rv && flight_q.size() > 0) begin
      e = flight_q.pop_front();
      take = !e.doomed && !k_br;
    end
    if (k_br) begin
      m_valid = 1'b0; m_pc = '0; m_inst = '0;
      exp_q.delete();
      foreach (flight_q[i]) flight_q[i].doomed = 1'b1;
      m_fetch_pc = k_tgt;
    end else if (!k_stall) begin
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        m_valid = 1'b1; m_pc = ent[63:32]; m_inst = ent[31:0];
      end else begin
        m_valid = 1'b0; m_pc = '0; m_inst = '0;
      end
    end
    if (take) exp_q.push_back({e.addr, fmt(mem_word(e.addr))});
    if (fire) begin
      flight_q.push_back('{addr: m_fetch_pc, doomed: 1'b0, due: cyc + int'($urandom_range(1, k_lat))});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
    chk("id_valid_o", 32'(id_valid_o), 32'(m_valid));
    chk("id_pc_o", id_pc_o, m_pc);
    chk("id_inst_o", id_inst_o, m_inst);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] epc, input logic [31:0] einst);
    int n = 0;
    while (!id_valid_o && n < 40) begin
      step();
      n++;
    end
    if (!id_valid_o) begin
      checks++;
      errors++;
      $display("FAIL %s: id_valid_o 0 after %0d cycles, expected 1", name, n);
    end else begin
      chk({name, "_pc"}, id_pc_o, epc);
      chk({name, "_inst"}, id_inst_o, einst);
    end
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      k_stall = ($urandom_range(0, 99) < 20);
      k_br    = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 3) == 0) k_tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
      else                           k_tgt = 32'($urandom_range(0, 511)) << 2;
      step();
    end
    k_stall = 0;
    k_br    = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] exp_pc;
    int          bubbles;
    int          seen;

    rst = 1'b0;
    drive_idle();
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_id_valid", 32'(id_valid_o), 32'd0);
    chk("rst_id_pc", id_pc_o, 32'd0);
    chk("rst_id_inst", id_inst_o, 32'd0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, RST_PC);
    rst = 1'b1;

    // Streaming from reset with immediate grants and 1-cycle responses, then a 4-cycle stall.
    k_gnt_pct = 100; k_rv_pct = 100; k_lat = 1;
    exp_pc = RST_PC; bubbles = 0; seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (id_valid_o) begin
        chk("seq_pc", id_pc_o, exp_pc);
        if (seen == 0) chk("first_inst", id_inst_o, FIRST_INST);
        if (seen == 1) chk("second_inst", id_inst_o, SECOND_INST);
        exp_pc = exp_pc + 32'd4;
        seen++;
      end else if (seen == 0) begin
        bubbles++;
      end
    end
    chk("lead_bubbles", 32'(bubbles), 32'd2);
    k_stall = 1;
    repeat (4) step();
    chk("stall_req_capped", 32'(imem_req_o), 32'd0);
    k_stall = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (id_valid_o) begin
        chk("seq_pc_after_stall", id_pc_o, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end

    // Redirect to 0x100 with two requests outstanding and one responding in the redirect cycle.
    k_gnt_pct = 0; k_rv_pct = 100;
    repeat (6) step();
    k_gnt_pct = 100; k_rv_pct = 0;
    repeat (3) step();
    k_br = 1; k_tgt = 32'h100; k_rv_pct = 100;
    step();
    chk("redirect_bubble", 32'(id_valid_o), 32'd0);
    k_br = 0;
    wait_valid("redirect", 32'h100, fmt(mem_word(32'h100)));

    // Redirect to 0x200 and withhold grants for 5 cycles.
    k_br = 1; k_tgt = 32'h200; k_gnt_pct = 0;
    step();
    k_br = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_addr", imem_addr_o, 32'h200);
      chk("hold_bubble", id_inst_o, 32'd0);
    end
    chk("hold_req", 32'(imem_req_o), 32'd1);
    k_gnt_pct = 100;
    wait_valid("gnt_resume", 32'h200, SWAP_INST);

    // Randomized traffic, including stray responses with nothing outstanding.
    k_spur = 1;
    for (int seg = 0; seg < 15; seg++) begin
      k_gnt_pct = $urandom_range(20, 100);
      k_rv_pct  = $urandom_range(20, 100);
      k_lat     = $urandom_range(1, 4);
      rand_steps(200);
    end

    // Asynchronous reset in the middle of traffic.
    rand_steps(40);
    #2 rst = 1'b0;
    #1;
    chk("midrst_id_valid", 32'(id_valid_o), 32'd0);
    chk("midrst_id_pc", id_pc_o, 32'd0);
    chk("midrst_id_inst", id_inst_o, 32'd0);
    chk("midrst_req", 32'(imem_req_o), 32'd0);
    chk("midrst_addr", imem_addr_o, RST_PC);
    drive_idle();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_addr", imem_addr_o, RST_PC);
    chk("post_rst_req", 32'(imem_req_o), 32'd1);
    rand_steps(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
